// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared proc opcode, field and feeder-state definitions
package proc_pkg;

    localparam logic [3:0] OP_LD   = 4'b0000;
    localparam logic [3:0] OP_ST   = 4'b0001;
    localparam logic [3:0] OP_MV   = 4'b0010;
    localparam logic [3:0] OP_MVNZ = 4'b0011;
    localparam logic [3:0] OP_MVI  = 4'b0100;
    localparam logic [3:0] OP_ADD  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_OR   = 4'b1000;
    localparam logic [3:0] OP_XOR  = 4'b1001;
    localparam logic [3:0] OP_SLL  = 4'b1010;
    localparam logic [3:0] OP_SRL  = 4'b1011;

    localparam logic [15:0] HALT_WORD = 16'hFFFF;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int X_HI   = 11;
    localparam int X_LO   = 9;
    localparam int Y_HI   = 8;
    localparam int Y_LO   = 6;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_WAITI,
        S_FETCHIMM,
        S_WAITIMM,
        S_EXEC,
        S_GAP1,
        S_GAP2,
        S_HALTED,
        S_ERROR
    } feeder_state_e;

    function automatic logic [3:0] opcode_of(input logic [15:0] word);
        return word[OPC_HI:OPC_LO];
    endfunction

endpackage

// File: rtl/feeder_watchdog.sv
// rtl/feeder_watchdog.sv - EXEC-cycle watchdog counter with load, enable and expire
module feeder_watchdog #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic expire
);

    localparam int unsigned W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt;

    // expire flags the TIMEOUT-th enabled cycle, so the caller sees exactly TIMEOUT cycles
    assign expire = enable && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || load) begin
            cnt <= '0;
        end else if (enable && !expire) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/proc_program_feeder.sv
// rtl/proc_program_feeder.sv - sequences ROM instructions into the proc via DIN/Run/Done
module proc_program_feeder
    import proc_pkg::*;
#(
    parameter int unsigned AW      = 8,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CW      = 16
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          Start,
    output logic [AW-1:0] rom_addr,
    input  logic [15:0]   rom_data,
    output logic [15:0]   DIN,
    output logic          Run,
    input  logic          Done,
    output logic          Busy,
    output logic          Halted,
    output logic          Timeout,
    output logic [CW-1:0] InstrCount
);

    feeder_state_e state, next_state;

    logic [AW-1:0] pc;
    logic [15:0]   instr;
    logic [15:0]   imm;
    logic          exec_first;
    logic          is_mvi;
    logic          start_ok;
    logic          wd_expire;

    assign is_mvi   = (opcode_of(instr) == OP_MVI);
    assign start_ok = Start && (state == S_IDLE || state == S_HALTED || state == S_ERROR);

    feeder_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk    (Clock),
        .reset  (Reset),
        .load   (state != S_EXEC),
        .enable (state == S_EXEC),
        .expire (wd_expire)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_HALTED, S_ERROR: if (Start) next_state = S_FETCH;
            S_FETCH:    next_state = S_WAITI;
            S_WAITI: begin
                if (rom_data == HALT_WORD)              next_state = S_HALTED;
                else if (opcode_of(rom_data) == OP_MVI) next_state = S_FETCHIMM;
                else                                    next_state = S_EXEC;
            end
            S_FETCHIMM: next_state = S_WAITIMM;
            S_WAITIMM:  next_state = S_EXEC;
            // Done takes priority over a watchdog expiry in the same cycle
            S_EXEC: begin
                if (Done)           next_state = S_GAP1;
                else if (wd_expire) next_state = S_ERROR;
            end
            S_GAP1:     next_state = S_GAP2;
            S_GAP2:     next_state = S_FETCH;
            default:    next_state = S_IDLE;
        endcase
    end

    // rom_addr is updated on the edge that enters FETCH/FETCHIMM so the sync ROM answers in the following WAIT state
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc         <= '0;
            rom_addr   <= '0;
            instr      <= '0;
            imm        <= '0;
            exec_first <= 1'b0;
            InstrCount <= '0;
        end else begin
            exec_first <= (next_state == S_EXEC) && (state != S_EXEC);
            if (start_ok) begin
                pc         <= '0;
                rom_addr   <= '0;
                InstrCount <= '0;
            end
            case (state)
                S_WAITI: begin
                    instr <= rom_data;
                    if (next_state == S_FETCHIMM) rom_addr <= pc + AW'(1);
                end
                S_WAITIMM: imm <= rom_data;
                S_EXEC: begin
                    if (Done) begin
                        pc <= pc + (is_mvi ? AW'(2) : AW'(1));
                        if (InstrCount != '1) InstrCount <= InstrCount + CW'(1);
                    end
                end
                S_GAP2:  rom_addr <= pc;
                default: ;
            endcase
        end
    end

    always_comb begin
        Run     = (state == S_EXEC);
        DIN     = '0;
        if (Run) DIN = (exec_first || !is_mvi) ? instr : imm;
        Busy    = !(state == S_IDLE || state == S_HALTED || state == S_ERROR);
        Halted  = (state == S_HALTED);
        Timeout = (state == S_ERROR);
    end

endmodule

// File: tb/tb_proc_program_feeder.sv
// tb/tb_proc_program_feeder.sv - scoreboard bench for proc_program_feeder
module tb_proc_program_feeder;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] nxt;
    } sb_item_t;

    localparam logic [15:0] W_MV   = 16'h2200;
    localparam logic [15:0] W_ADD  = 16'h5240;
    localparam logic [15:0] W_SUB  = 16'h6280;
    localparam logic [15:0] W_MVI  = 16'h4400;
    localparam logic [15:0] W_HALT = 16'hFFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start_a, done_a, start_w, done_w, sel;
    logic [7:0]  rom_addr_a;
    logic [15:0] rom_data_a, din_a, cnt_a;
    logic        run_a, busy_a, halted_a, timeout_a;
    logic [1:0]  rom_addr_w;
    logic [15:0] rom_data_w, din_w;
    logic [3:0]  cnt_w;
    logic        run_w, busy_w, halted_w, timeout_w;

    logic [15:0] rom_a [256];
    logic [15:0] rom_w [4];

    always @(posedge clk) rom_data_a <= rom_a[rom_addr_a];
    always @(posedge clk) rom_data_w <= rom_w[rom_addr_w];

    proc_program_feeder #(.AW(8), .TIMEOUT(16), .CW(16)) u_dut (
        .Clock(clk), .Reset(reset), .Start(start_a), .rom_addr(rom_addr_a), .rom_data(rom_data_a),
        .DIN(din_a), .Run(run_a), .Done(done_a), .Busy(busy_a), .Halted(halted_a),
        .Timeout(timeout_a), .InstrCount(cnt_a)
    );

    proc_program_feeder #(.AW(2), .TIMEOUT(16), .CW(4)) u_dut_wrap (
        .Clock(clk), .Reset(reset), .Start(start_w), .rom_addr(rom_addr_w), .rom_data(rom_data_w),
        .DIN(din_w), .Run(run_w), .Done(done_w), .Busy(busy_w), .Halted(halted_w),
        .Timeout(timeout_w), .InstrCount(cnt_w)
    );

    logic        run_s, halted_s;
    logic [15:0] din_s;
    assign run_s    = sel ? run_w : run_a;
    assign halted_s = sel ? halted_w : halted_a;
    assign din_s    = sel ? din_w : din_a;

    sb_item_t sb_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [15:0] instr, input logic [15:0] nxt);
        sb_item_t e;
        e.instr = instr;
        e.nxt   = nxt;
        sb_q.push_back(e);
    endtask

    task automatic set_done(input logic v);
        if (sel) done_w = v;
        else     done_a = v;
    endtask

    task automatic start_and_measure(output int lat);
        if (sel) start_w = 1'b1;
        else     start_a = 1'b1;
        tick;
        start_a = 1'b0;
        start_w = 1'b0;
        lat = 1;
        while (!run_s && lat < 20) begin
            tick;
            lat++;
        end
    endtask

    task automatic exec_one(input int delay);
        sb_item_t e;
        int n;
        if (sb_q.size() == 0) begin
            check("sb_empty", 1, 0);
            return;
        end
        e = sb_q.pop_front();
        n = 0;
        while (!run_s && n < 30) begin
            tick;
            n++;
        end
        check("run_seen", run_s, 1);
        if (!run_s) return;
        check("din_first", din_s, e.instr);
        for (int k = 0; k < delay; k++) begin
            tick;
            check("run_hold", run_s, 1);
            check("din_later", din_s, e.nxt);
        end
        set_done(1'b1);
        tick;
        set_done(1'b0);
        check("run_drop", run_s, 0);
    endtask

    task automatic wait_halt;
        int n;
        n = 0;
        while (!halted_s && n < 40) begin
            tick;
            n++;
        end
        check("halted", halted_s, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int lat, n, pcm, expc;
        logic [15:0] w;
        sb_item_t e;
        for (int i = 0; i < 256; i++) rom_a[i] = 16'h0;
        for (int i = 0; i < 4; i++)   rom_w[i] = 16'h0;
        sel = 1'b0; reset = 1'b1; start_a = 1'b0; done_a = 1'b0; start_w = 1'b0; done_w = 1'b0;
        tick;
        tick;
        check("rst_rom_addr", rom_addr_a, 0);
        check("rst_din", din_a, 0);
        check("rst_run", run_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_halted", halted_a, 0);
        check("rst_timeout", timeout_a, 0);
        check("rst_count", cnt_a, 0);
        reset = 1'b0;
        tick;

        // Done in IDLE is ignored
        done_a = 1'b1;
        tick;
        done_a = 1'b0;
        check("idle_done_busy", busy_a, 0);
        check("idle_done_count", cnt_a, 0);

        // mv R1,R0 ; HALT
        rom_a[0] = W_MV; rom_a[1] = W_HALT;
        push(W_MV, W_MV);
        start_and_measure(lat);
        check("lat_mv", lat, 3);
        exec_one(1);
        done_a = 1'b1;
        tick;
        done_a = 1'b0;
        check("gap_done_count", cnt_a, 1);
        wait_halt;
        check("mv_count", cnt_a, 1);
        check("mv_busy", busy_a, 0);
        check("mv_run", run_a, 0);

        // mvi R2 ; 00A5 ; HALT
        rom_a[0] = W_MVI; rom_a[1] = 16'h00A5; rom_a[2] = W_HALT;
        push(W_MVI, 16'h00A5);
        start_and_measure(lat);
        check("lat_mvi", lat, 5);
        check("restart_clr_halted", halted_a, 0);
        exec_one(2);
        wait_halt;
        check("mvi_count", cnt_a, 1);
        check("mvi_pc_plus2", rom_addr_a, 2);

        // Watchdog: second instruction never gets Done
        rom_a[0] = W_MV; rom_a[1] = W_ADD; rom_a[2] = W_HALT;
        push(W_MV, W_MV);
        start_and_measure(lat);
        exec_one(1);
        n = 0;
        while (!run_a && n < 30) begin
            tick;
            n++;
        end
        check("wd_din", din_a, W_ADD);
        n = 0;
        while (run_a && n < 40) begin
            n++;
            tick;
        end
        check("wd_cycles", n, 16);
        check("wd_timeout", timeout_a, 1);
        check("wd_busy", busy_a, 0);
        check("wd_count", cnt_a, 1);
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
        check("wd_restart_timeout", timeout_a, 0);
        check("wd_restart_busy", busy_a, 1);
        check("wd_restart_addr", rom_addr_a, 0);
        check("wd_restart_count", cnt_a, 0);
        push(W_MV, W_MV);
        push(W_ADD, W_ADD);
        exec_one(15);
        check("done_beats_wd", timeout_a, 0);
        exec_one(1);
        wait_halt;
        check("wd_restart_final", cnt_a, 2);
        check("wd_restart_halt_addr", rom_addr_a, 2);

        // Reset during EXEC of the second instruction
        rom_a[0] = W_MV; rom_a[1] = W_SUB; rom_a[2] = W_HALT;
        push(W_MV, W_MV);
        start_and_measure(lat);
        exec_one(0);
        n = 0;
        while (!run_a && n < 30) begin
            tick;
            n++;
        end
        check("pre_rst_din", din_a, W_SUB);
        check("pre_rst_addr", rom_addr_a, 1);
        reset = 1'b1;
        tick;
        check("mid_rst_run", run_a, 0);
        check("mid_rst_din", din_a, 0);
        check("mid_rst_addr", rom_addr_a, 0);
        check("mid_rst_busy", busy_a, 0);
        check("mid_rst_count", cnt_a, 0);
        reset = 1'b0;
        tick;
        push(W_MV, W_MV);
        push(W_SUB, W_SUB);
        start_and_measure(lat);
        check("post_rst_lat", lat, 3);
        exec_one(1);
        exec_one(1);
        wait_halt;
        check("post_rst_count", cnt_a, 2);

        // AW=2 wrap, mvi at last address, 4-bit count saturation
        sel = 1'b1;
        rom_w[0] = W_MV; rom_w[1] = W_ADD; rom_w[2] = W_SUB; rom_w[3] = W_MVI;
        pcm = 0;
        start_and_measure(lat);
        check("wrap_lat", lat, 3);
        for (int i = 0; i < 18; i++) begin
            w = rom_w[pcm];
            if (w == W_MVI) begin
                push(w, rom_w[(pcm + 1) % 4]);
                pcm = (pcm + 2) % 4;
                exec_one(1);
            end else begin
                push(w, w);
                pcm = (pcm + 1) % 4;
                exec_one(0);
            end
            expc = (i + 1 > 15) ? 15 : i + 1;
            check("wrap_count", cnt_w, expc);
            check("wrap_busy", busy_w, 1);
            if (i == 5) begin
                start_w = 1'b1;
                tick;
                start_w = 1'b0;
                check("busy_start_ignored", cnt_w, 6);
            end
        end
        check("wrap_no_timeout", timeout_w, 0);
        check("sb_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
